uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter for the FPGA raytracer's debug/readback path. It accepts words from the system clock domain into an internal FIFO and serialises them on `uart_tx_o`. Data width, parity and stop-bit count are configurable. Baud rate comes from a fractional accumulator driven by `CLK_HZ`/`BAUD`. Producers can burst words without polling busy per byte; frames are sent back-to-back with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter for the raytracer debug/readback path. Words
// written from the system clock domain are queued in a small FIFO and sent
// back-to-back on uart_tx_o. The bit rate is produced by a fractional
// accumulator, so CLK_HZ does not need to be a multiple of BAUD.
//
// Parameters:
//   CLK_HZ      system clock frequency in Hz
//   BAUD        line rate (2*BAUD <= CLK_HZ)
//   DATA_BITS   payload bits per frame, 5..9
//   PARITY      0 = none, 1 = odd, 2 = even
//   STOP_BITS   1 or 2
//   FIFO_DEPTH  entries, power of two, >= 2
//
// Ports:
//   sys_clk_i     system clock
//   sys_rst_n_i   asynchronous active-low reset
//   uart_wr_i     single-cycle write strobe
//   uart_dat_i    word to enqueue
//   uart_full_o   FIFO full
//   uart_empty_o  FIFO empty
//   uart_level_o  FIFO occupancy, 0..FIFO_DEPTH
//   uart_drop_o   one-cycle pulse when a write is rejected
//   uart_busy_o   high while a frame is on the line
//   uart_tx_o     serial output, idle high
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int CLK_HZ     = 150000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_n_i,
  input  logic                          uart_wr_i,
  input  logic [DATA_BITS-1:0]          uart_dat_i,
  output logic                          uart_full_o,
  output logic                          uart_empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
  output logic                          uart_drop_o,
  output logic                          uart_busy_o,
  output logic                          uart_tx_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam int ACC_W = $clog2(CLK_HZ) + 1;
  localparam int CNT_W = $clog2(DATA_BITS + 1);

  localparam logic [ACC_W-1:0] CLK_C     = ACC_W'(CLK_HZ);
  localparam logic [ACC_W-1:0] BAUD_C    = ACC_W'(BAUD);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        level;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic                 drop_q;
  logic [DATA_BITS-1:0] head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // and the difference is the occupancy directly.
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == PW'(FIFO_DEPTH));
  assign empty = (wr_ptr == rd_ptr);
  assign push  = uart_wr_i && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // A write against a full FIFO is rejected even if a pop frees a slot
      // in the same cycle.
      drop_q <= uart_wr_i && full;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= uart_dat_i;
    end
  end

  // --------------------------------------------------------------------------
  // Fractional baud accumulator
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             tick;
  state_t           state_q;
  state_t           state_d;

  assign acc_sum = acc + BAUD_C;
  assign tick    = (acc_sum >= CLK_C);

  // Clearing on the pop out of IDLE aligns the first bit period to the start
  // bit; back-to-back frames keep the running phase so no error accumulates.
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      acc <= '0;
    end else if (state_q == ST_IDLE && !empty) begin
      acc <= '0;
    end else if (tick) begin
      acc <= acc_sum - CLK_C;
    end else begin
      acc <= acc_sum;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [CNT_W-1:0]     bit_q;
  logic [CNT_W-1:0]     bit_d;
  logic                 stop_q;
  logic                 stop_d;
  logic                 par_q;
  logic                 par_d;
  logic                 par_load;
  logic                 tx_q;
  logic                 tx_d;

  assign par_load = (PARITY == 1) ? ~(^head) : (^head);

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    par_d   = par_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ST_START;
          shift_d = head;
          par_d   = par_load;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d = ST_DATA;
          bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            // Chain straight into the next start bit when more data waits.
            if (!empty) begin
              pop     = 1'b1;
              state_d = ST_START;
              shift_d = head;
              par_d   = par_load;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The line level is derived from the next state and registered, so the
  // output never glitches during state changes.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  assign uart_tx_o    = tx_q;
  assign uart_busy_o  = (state_q != ST_IDLE);
  assign uart_full_o  = full;
  assign uart_empty_o = empty;
  assign uart_level_o = level;
  assign uart_drop_o  = drop_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Four uart_tx_fifo instances with different configurations share one clock
// and reset:
//   u0  16 Hz / 1 baud, 8N1, depth 4
//   u1  16 Hz / 1 baud, 8E1, depth 16
//   u2  16 Hz / 1 baud, 7O2, depth 16
//   u3  150 MHz / 115200 baud, 8N1, depth 16
// A queue-and-arithmetic model predicts every output each cycle; directed
// tests add hand-derived expectations on top of it.
// ----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int P_CLK   [4] = '{16, 16, 16, 150000000};
  localparam int P_BAUD  [4] = '{1, 1, 1, 115200};
  localparam int P_DB    [4] = '{8, 8, 7, 8};
  localparam int P_PAR   [4] = '{0, 2, 1, 0};
  localparam int P_STOP  [4] = '{1, 1, 2, 1};
  localparam int P_DEPTH [4] = '{4, 16, 16, 16};

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr    [4];
  logic [8:0] dat   [4];
  logic       tx    [4];
  logic       busy  [4];
  logic       full  [4];
  logic       empty [4];
  logic       drop  [4];
  logic [2:0] lvl0;
  logic [4:0] lvl1;
  logic [4:0] lvl2;
  logic [4:0] lvl3;

  int     checks   = 0;
  int     errors   = 0;
  longint edge_cnt = 0;

  // Model state
  int     m_mem    [4][16];
  int     m_head   [4];
  int     m_cnt    [4];
  bit     m_busy   [4];
  bit     m_drop   [4];
  longint m_origin [4];
  longint m_nbit   [4];
  int     m_fbits  [4][16];
  int     m_flen   [4];
  int     m_fpos   [4];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(P_CLK[0]), .BAUD(P_BAUD[0]), .DATA_BITS(P_DB[0]),
                 .PARITY(P_PAR[0]), .STOP_BITS(P_STOP[0]), .FIFO_DEPTH(P_DEPTH[0])) u0 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .uart_wr_i(wr[0]), .uart_dat_i(dat[0][7:0]),
    .uart_full_o(full[0]), .uart_empty_o(empty[0]), .uart_level_o(lvl0),
    .uart_drop_o(drop[0]), .uart_busy_o(busy[0]), .uart_tx_o(tx[0]));

  uart_tx_fifo #(.CLK_HZ(P_CLK[1]), .BAUD(P_BAUD[1]), .DATA_BITS(P_DB[1]),
                 .PARITY(P_PAR[1]), .STOP_BITS(P_STOP[1]), .FIFO_DEPTH(P_DEPTH[1])) u1 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .uart_wr_i(wr[1]), .uart_dat_i(dat[1][7:0]),
    .uart_full_o(full[1]), .uart_empty_o(empty[1]), .uart_level_o(lvl1),
    .uart_drop_o(drop[1]), .uart_busy_o(busy[1]), .uart_tx_o(tx[1]));

  uart_tx_fifo #(.CLK_HZ(P_CLK[2]), .BAUD(P_BAUD[2]), .DATA_BITS(P_DB[2]),
                 .PARITY(P_PAR[2]), .STOP_BITS(P_STOP[2]), .FIFO_DEPTH(P_DEPTH[2])) u2 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .uart_wr_i(wr[2]), .uart_dat_i(dat[2][6:0]),
    .uart_full_o(full[2]), .uart_empty_o(empty[2]), .uart_level_o(lvl2),
    .uart_drop_o(drop[2]), .uart_busy_o(busy[2]), .uart_tx_o(tx[2]));

  uart_tx_fifo #(.CLK_HZ(P_CLK[3]), .BAUD(P_BAUD[3]), .DATA_BITS(P_DB[3]),
                 .PARITY(P_PAR[3]), .STOP_BITS(P_STOP[3]), .FIFO_DEPTH(P_DEPTH[3])) u3 (
    .sys_clk_i(clk), .sys_rst_n_i(rst_n), .uart_wr_i(wr[3]), .uart_dat_i(dat[3][7:0]),
    .uart_full_o(full[3]), .uart_empty_o(empty[3]), .uart_level_o(lvl3),
    .uart_drop_o(drop[3]), .uart_busy_o(busy[3]), .uart_tx_o(tx[3]));

  function automatic logic [4:0] lvlOf(int i);
    case (i)
      0:       return {2'b00, lvl0};
      1:       return lvl1;
      2:       return lvl2;
      default: return lvl3;
    endcase
  endfunction

  // Edge (counted from the frame origin) at which cumulative bit n ends:
  // the first edge j with floor(j*BAUD/CLK) >= n+1.
  function automatic longint bitEnd(int i, longint n);
    return ((n + 1) * longint'(P_CLK[i]) + longint'(P_BAUD[i]) - 1) / longint'(P_BAUD[i]);
  endfunction

  task automatic loadFrame(int i, int w);
    int ones;
    int pos;
    ones = 0;
    m_fbits[i][0] = 0;
    for (int b = 0; b < P_DB[i]; b++) begin
      m_fbits[i][1 + b] = (w >> b) & 1;
      ones += (w >> b) & 1;
    end
    pos = 1 + P_DB[i];
    if (P_PAR[i] == 1) begin
      m_fbits[i][pos] = (ones % 2 == 0) ? 1 : 0;
      pos++;
    end else if (P_PAR[i] == 2) begin
      m_fbits[i][pos] = ones % 2;
      pos++;
    end
    for (int s = 0; s < P_STOP[i]; s++) begin
      m_fbits[i][pos] = 1;
      pos++;
    end
    m_flen[i] = pos;
    m_fpos[i] = 0;
  endtask

  task automatic modelStep();
    bit full_pre;
    bit do_pop;
    edge_cnt++;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        m_cnt[i]  = 0;
        m_head[i] = 0;
        m_busy[i] = 1'b0;
        m_drop[i] = 1'b0;
        m_fpos[i] = 0;
      end else begin
        full_pre = (m_cnt[i] == P_DEPTH[i]);
        do_pop   = 1'b0;
        if (m_busy[i]) begin
          if (edge_cnt - m_origin[i] == bitEnd(i, m_nbit[i])) begin
            m_nbit[i]++;
            m_fpos[i]++;
            if (m_fpos[i] == m_flen[i]) begin
              if (m_cnt[i] > 0) do_pop = 1'b1;
              else m_busy[i] = 1'b0;
            end
          end
        end else if (m_cnt[i] > 0) begin
          do_pop      = 1'b1;
          m_busy[i]   = 1'b1;
          m_origin[i] = edge_cnt;
          m_nbit[i]   = 0;
        end
        if (do_pop) begin
          loadFrame(i, m_mem[i][m_head[i]]);
          m_head[i] = (m_head[i] + 1) % 16;
          m_cnt[i]--;
        end
        m_drop[i] = wr[i] && full_pre;
        if (wr[i] && !full_pre) begin
          m_mem[i][(m_head[i] + m_cnt[i]) % 16] = int'(dat[i]) & ((1 << P_DB[i]) - 1);
          m_cnt[i]++;
        end
      end
    end
  endtask

  task automatic compareAll();
    logic       e_tx, e_busy, e_full, e_empty, e_drop;
    logic [4:0] e_lvl;
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) begin
        e_tx = 1'b1; e_busy = 1'b0; e_full = 1'b0; e_empty = 1'b1; e_drop = 1'b0; e_lvl = 5'd0;
      end else begin
        e_tx    = (m_busy[i] && m_fbits[i][m_fpos[i]] == 0) ? 1'b0 : 1'b1;
        e_busy  = m_busy[i];
        e_full  = (m_cnt[i] == P_DEPTH[i]);
        e_empty = (m_cnt[i] == 0);
        e_drop  = m_drop[i];
        e_lvl   = 5'(m_cnt[i]);
      end
      checks++;
      if (tx[i] !== e_tx || busy[i] !== e_busy || full[i] !== e_full ||
          empty[i] !== e_empty || drop[i] !== e_drop || lvlOf(i) !== e_lvl) begin
        errors++;
        $display("[TB] FAIL model_u%0d edge %0d: tx/busy/full/empty/drop/level actual %b/%b/%b/%b/%b/%0d required %b/%b/%b/%b/%b/%0d",
                 i, edge_cnt, tx[i], busy[i], full[i], empty[i], drop[i], lvlOf(i),
                 e_tx, e_busy, e_full, e_empty, e_drop, e_lvl);
      end
    end
  endtask

  task automatic checkOutput(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual %0d required %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(string name, int actual, int lo, int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s actual %0d required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Cycle c is the interval after edge (base + c - 1); edge base is the write.
  task automatic waitCycle(longint base, int c);
    do @(negedge clk); while (edge_cnt - base + 1 < longint'(c));
  endtask

  task automatic applyStimulus(int i, int w, output longint base);
    @(posedge clk); #2;
    wr[i]  = 1'b1;
    dat[i] = 9'(w);
    @(posedge clk); #2;
    base   = edge_cnt;
    wr[i]  = 1'b0;
  endtask

  task automatic burstWrite(int i, int n, int first, int stride, output longint base);
    base = 0;
    @(posedge clk); #2;
    wr[i]  = 1'b1;
    dat[i] = 9'(first);
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #2;
      if (k == 1) base = edge_cnt;
      dat[i] = 9'(first + k * stride);
    end
    @(posedge clk); #2;
    wr[i] = 1'b0;
  endtask

  function automatic int a5Tx(int c);
    logic [7:0] w;
    w = 8'hA5;
    if (c >= 2 && c <= 17) return 0;
    if (c >= 18 && c <= 145) return int'(w[(c - 18) / 16]);
    return 1;
  endfunction

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  initial forever begin
    @(negedge clk);
    compareAll();
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    longint base;
    longint b2;
    logic   prev;
    int     run;
    int     seg;
    int     total;

    for (int i = 0; i < 4; i++) begin
      wr[i] = 1'b0; dat[i] = '0; m_cnt[i] = 0; m_head[i] = 0; m_busy[i] = 1'b0;
      m_drop[i] = 1'b0; m_fpos[i] = 0; m_flen[i] = 1; m_nbit[i] = 0; m_origin[i] = 0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("rst_tx", int'(tx[0]), 1);
    checkOutput("rst_busy", int'(busy[0]), 0);
    checkOutput("rst_full", int'(full[0]), 0);
    checkOutput("rst_empty", int'(empty[0]), 1);
    checkOutput("rst_level", int'(lvl0), 0);
    checkOutput("rst_drop", int'(drop[0]), 0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single 8N1 frame of 0xA5
    $display("[TB] single frame 0xA5");
    applyStimulus(0, 'hA5, base);
    for (int c = 1; c <= 165; c++) begin
      waitCycle(base, c);
      checkOutput($sformatf("a5_tx_c%0d", c), int'(tx[0]), a5Tx(c));
      checkOutput($sformatf("a5_busy_c%0d", c), int'(busy[0]), (c >= 2 && c <= 161) ? 1 : 0);
    end

    // Even parity, 8E1
    $display("[TB] even parity");
    applyStimulus(1, 'h55, base);
    waitCycle(base, 150); checkOutput("e55_parity", int'(tx[1]), 0);
    waitCycle(base, 170); checkOutput("e55_stop", int'(tx[1]), 1);
    waitCycle(base, 177); checkOutput("e55_busy_last", int'(busy[1]), 1);
    waitCycle(base, 178); checkOutput("e55_busy_end", int'(busy[1]), 0);
    applyStimulus(1, 'h01, base);
    waitCycle(base, 140); checkOutput("e01_bit7", int'(tx[1]), 0);
    waitCycle(base, 150); checkOutput("e01_parity", int'(tx[1]), 1);
    waitCycle(base, 178); checkOutput("e01_busy_end", int'(busy[1]), 0);

    // Odd parity, 7O2
    $display("[TB] odd parity two stop bits");
    applyStimulus(2, 'h7F, base);
    waitCycle(base, 125); checkOutput("o7f_bit6", int'(tx[2]), 1);
    waitCycle(base, 140); checkOutput("o7f_parity", int'(tx[2]), 0);
    waitCycle(base, 150); checkOutput("o7f_stop1", int'(tx[2]), 1);
    waitCycle(base, 170); checkOutput("o7f_stop2", int'(tx[2]), 1);
    waitCycle(base, 177); checkOutput("o7f_busy_last", int'(busy[2]), 1);
    waitCycle(base, 178); checkOutput("o7f_busy_end", int'(busy[2]), 0);

    // Back-to-back frames and overflow on the depth-4 instance
    $display("[TB] burst and overflow");
    b2 = 0;
    fork
      burstWrite(0, 6, 'h11, 'h11, base);
      begin
        @(posedge clk); @(posedge clk); #3;
        b2 = edge_cnt;
        waitCycle(b2, 5);
        checkOutput("burst_level_full", int'(lvl0), 4);
        checkOutput("burst_full", int'(full[0]), 1);
        checkOutput("burst_not_empty", int'(empty[0]), 0);
        waitCycle(b2, 6);
        checkOutput("burst_drop_pulse", int'(drop[0]), 1);
        waitCycle(b2, 7);
        checkOutput("burst_drop_clear", int'(drop[0]), 0);
      end
    join
    for (int c = 8; c <= 802; c++) begin
      waitCycle(b2, c);
      checkOutput($sformatf("burst_busy_c%0d", c), int'(busy[0]), (c <= 801) ? 1 : 0);
      if (c == 161) begin
        checkOutput("burst_level_pre_pop", int'(lvl0), 4);
        checkOutput("burst_stop_high", int'(tx[0]), 1);
      end
      if (c == 162) begin
        checkOutput("burst_level_post_pop", int'(lvl0), 3);
        checkOutput("burst_no_gap_start", int'(tx[0]), 0);
      end
    end
    checkOutput("burst_level_drained", int'(lvl0), 0);
    checkOutput("burst_empty_end", int'(empty[0]), 1);

    // Fractional baud
    $display("[TB] fractional baud");
    applyStimulus(3, 'h55, base);
    waitCycle(base, 2);
    checkOutput("frac_start_low", int'(tx[3]), 0);
    prev  = tx[3];
    run   = 1;
    seg   = 0;
    total = 1;
    for (int g = 0; g < 20000 && busy[3]; g++) begin
      @(negedge clk);
      if (busy[3]) begin
        total++;
        if (tx[3] != prev) begin
          checkRange($sformatf("frac_bit%0d", seg), run, 1302, 1303);
          seg++;
          run  = 1;
          prev = tx[3];
        end else begin
          run++;
        end
      end
    end
    checkOutput("frac_busy_done", int'(busy[3]), 0);
    checkOutput("frac_toggles", seg, 9);
    checkRange("frac_stop_bit", run, 1302, 1303);
    checkRange("frac_frame", total, 13020, 13021);

    // Reset in the middle of a frame with three words queued
    $display("[TB] reset mid-frame");
    burstWrite(0, 4, 0, 0, base);
    waitCycle(base, 60);
    checkOutput("rmf_pre_tx", int'(tx[0]), 0);
    checkOutput("rmf_pre_level", int'(lvl0), 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rmf_async_tx", int'(tx[0]), 1);
    checkOutput("rmf_async_busy", int'(busy[0]), 0);
    checkOutput("rmf_async_level", int'(lvl0), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rmf_tx_%0d", c), int'(tx[0]), 1);
      checkOutput($sformatf("rmf_busy_%0d", c), int'(busy[0]), 0);
      checkOutput($sformatf("rmf_level_%0d", c), int'(lvl0), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
